// File: rtl/store_drain_buffer.sv
// store_drain_buffer: captures in-window CPU stores into a FIFO and drains them over valid/ready.
// Ports: clk, reset (async active-low), MemWrite/DataAdr/WriteData in, out_valid/out_ready/out_addr/out_data,
//        count, full, drop_cnt, overflow. Optional macro STORE_DRAIN_COALESCE_EN merges stores to the youngest address.
module store_drain_buffer #(
    parameter int          DEPTH    = 8,
    parameter logic [31:0] WIN_BASE = 32'h0000_0000,
    parameter logic [31:0] WIN_MASK = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       MemWrite,
    input  logic [31:0]                DataAdr,
    input  logic [31:0]                WriteData,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_addr,
    output logic [31:0]                out_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic [15:0]                drop_cnt,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] ONE  = CW'(1);
    localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_PARTIAL,
        S_FULL
    } state_t;

    state_t          state;
    logic [AW-1:0]   head;
    logic [AW-1:0]   tail;
    logic [CW-1:0]   cnt;
    logic [31:0]     mem_addr [DEPTH];
    logic [31:0]     mem_data [DEPTH];

    logic hit;
    logic pop;
    logic push;
    logic drop;
    logic coal;

    assign hit = MemWrite & ((DataAdr & WIN_MASK) == (WIN_BASE & WIN_MASK));
    assign pop = out_valid & out_ready;

`ifdef STORE_DRAIN_COALESCE_EN
    logic [AW-1:0] youngest;
    assign youngest = tail - AW'(1);
    // Merging into an entry that leaves this cycle would lose the store,
    // so a lone head being popped falls back to the normal push path.
    assign coal = hit & (state != S_EMPTY)
                & (mem_addr[youngest] == DataAdr)
                & ~((cnt == ONE) & pop);
`else
    assign coal = 1'b0;
`endif

    // A pop in the same cycle never frees space for a store while full.
    assign push = hit & ~full & ~coal;
    assign drop = hit & full & ~coal;

    assign out_valid = (state != S_EMPTY);
    assign full      = (state == S_FULL);
    assign count     = cnt;
    assign out_addr  = out_valid ? mem_addr[head] : 32'h0;
    assign out_data  = out_valid ? mem_data[head] : 32'h0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[tail] <= DataAdr;
            mem_data[tail] <= WriteData;
        end
`ifdef STORE_DRAIN_COALESCE_EN
        else if (coal) begin
            mem_data[youngest] <= WriteData;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_EMPTY;
            head     <= '0;
            tail     <= '0;
            cnt      <= '0;
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) tail <= tail + AW'(1);
            if (pop)  head <= head + AW'(1);

            unique case ({push, pop})
                2'b10:   cnt <= cnt + ONE;
                2'b01:   cnt <= cnt - ONE;
                default: cnt <= cnt;
            endcase

            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            end

            unique case (state)
                S_EMPTY: begin
                    if (push && !pop) state <= S_PARTIAL;
                end
                S_PARTIAL: begin
                    if (push && !pop && cnt == LAST) state <= S_FULL;
                    else if (pop && !push && cnt == ONE) state <= S_EMPTY;
                end
                S_FULL: begin
                    if (pop) state <= S_PARTIAL;
                end
                default: state <= S_EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_store_drain_buffer.sv
// tb_store_drain_buffer: directed checks of store_drain_buffer.
// Second instance uses a narrowed address window.
module tb_store_drain_buffer;

    logic        clk;
    logic        reset;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic        out_ready;

    logic        out_valid;
    logic [31:0] out_addr;
    logic [31:0] out_data;
    logic [3:0]  count;
    logic        full;
    logic [15:0] drop_cnt;
    logic        overflow;

    logic        w_valid;
    logic [31:0] w_addr;
    logic [31:0] w_data;
    logic [3:0]  w_count;
    logic        w_full;
    logic [15:0] w_drop;
    logic        w_ovf;

    int n_cmp;
    int n_bad;

    store_drain_buffer #(.DEPTH(8)) dut (
        .clk(clk), .reset(reset),
        .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data),
        .count(count), .full(full),
        .drop_cnt(drop_cnt), .overflow(overflow)
    );

    store_drain_buffer #(
        .DEPTH(8),
        .WIN_BASE(32'h8000_0000),
        .WIN_MASK(32'hF000_0000)
    ) u_win (
        .clk(clk), .reset(reset),
        .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
        .out_valid(w_valid), .out_ready(out_ready),
        .out_addr(w_addr), .out_data(w_data),
        .count(w_count), .full(w_full),
        .drop_cnt(w_drop), .overflow(w_ovf)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        MemWrite  = 1'b1;
        DataAdr   = a;
        WriteData = d;
        tick();
        MemWrite  = 1'b0;
    endtask

    logic [31:0] q[$];
    int          pre;
    bit          mw;
    bit          rdy;
    int          guard;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b0;
        MemWrite = 1'b0;
        DataAdr = '0;
        WriteData = '0;
        out_ready = 1'b0;

        #14;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_addr", out_addr, 32'd0);
        chk("rst_data", out_data, 32'd0);
        #1;
        reset = 1'b1;

        store(32'h64, 32'd7);
        chk("one_valid", 32'(out_valid), 32'd1);
        chk("one_addr", out_addr, 32'h64);
        chk("one_data", out_data, 32'd7);
        chk("one_count", 32'(count), 32'd1);
        out_ready = 1'b1;
        tick();
        chk("one_popped", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        for (int i = 0; i < 10; i++) begin
            store(32'(i * 4), 32'(100 + i));
            if (i == 7) chk("fill_full8", 32'(full), 32'd1);
        end
        chk("fill_count", 32'(count), 32'd8);
        chk("fill_drop", 32'(drop_cnt), 32'd2);
        chk("fill_ovf", 32'(overflow), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("drain_addr", out_addr, 32'(i * 4));
            chk("drain_data", out_data, 32'(100 + i));
            tick();
        end
        chk("drain_empty", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        store(32'h100, 32'd1);
        store(32'h104, 32'd2);
        store(32'h108, 32'd3);
        chk("pp_pre", 32'(count), 32'd3);
        out_ready = 1'b1;
        store(32'h10C, 32'd4);
        chk("pp_count", 32'(count), 32'd3);
        chk("pp_head", out_addr, 32'h104);
        q = {32'h104, 32'h108, 32'h10C};

        for (int i = 0; i < 20; i++) begin
            mw  = (i % 3) != 2;
            rdy = (i % 2) == 1;
            MemWrite  = mw;
            DataAdr   = 32'h200 + 32'(i * 4);
            WriteData = 32'(i);
            out_ready = rdy;
            pre = q.size();
            if (pre > 0) chk("mix_head", out_addr, q[0]);
            if (rdy && pre > 0) void'(q.pop_front());
            if (mw && pre < 8) q.push_back(32'h200 + 32'(i * 4));
            tick();
            chk("mix_count", 32'(count), 32'(q.size()));
        end
        MemWrite = 1'b0;
        out_ready = 1'b1;
        guard = 0;
        while (out_valid && guard < 20) begin
            chk("mix_drain", out_addr, q[0]);
            void'(q.pop_front());
            tick();
            guard++;
        end
        chk("mix_done", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        for (int i = 0; i < 5; i++) store(32'h300 + 32'(i * 4), 32'(i));
        chk("mid_pre", 32'(count), 32'd5);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_count", 32'(count), 32'd0);
        chk("mid_valid", 32'(out_valid), 32'd0);
        chk("mid_drop", 32'(drop_cnt), 32'd0);
        chk("mid_ovf", 32'(overflow), 32'd0);
        #2;
        reset = 1'b1;
        tick();

        store(32'h64, 32'd9);
        store(32'h8000_0010, 32'd10);
        chk("win_count", 32'(w_count), 32'd1);
        chk("win_addr", w_addr, 32'h8000_0010);
        chk("win_data", w_data, 32'd10);
        chk("win_main", 32'(count), 32'd2);

        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        chk("co_pre", 32'(count), 32'd0);
        store(32'h20, 32'd1);
        store(32'h20, 32'd2);
        store(32'h20, 32'd3);
`ifdef STORE_DRAIN_COALESCE_EN
        chk("co_count", 32'(count), 32'd1);
        chk("co_data", out_data, 32'd3);
`else
        chk("co_count", 32'(count), 32'd3);
        chk("co_data", out_data, 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
